// File: rtl/uart_pkg.sv
// Shared state type, frame constants and the majority-vote helper for the
// oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_W   = $clog2(OVERSAMPLE);

  localparam logic [SAMPLE_W-1:0] VOTE_EARLY = SAMPLE_W'(7);
  localparam logic [SAMPLE_W-1:0] VOTE_MID   = SAMPLE_W'(8);
  localparam logic [SAMPLE_W-1:0] VOTE_LATE  = SAMPLE_W'(9);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO holding received bytes; a push while full is
// accepted only when a pop frees a slot in the same clock.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority voting and a
// byte FIFO on the output side.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TICK_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS);

  rx_state_t             state;
  rx_state_t             next_state;
  logic                  rxd_meta;
  logic                  rxd_sync;
  logic [1:0]            sync_primed;
  logic [TICK_W-1:0]     tick_cnt;
  logic                  tick;
  logic [SAMPLE_W-1:0]   sample_cnt;
  logic [SAMPLE_W-1:0]   sample_idx;
  logic                  samp_early;
  logic                  samp_mid;
  logic                  vote;
  logic                  at_vote;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  armed;
  logic                  push;
  logic                  frame_bad;
  logic                  fifo_empty;
  logic                  fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta    <= 1'b1;
      rxd_sync    <= 1'b1;
      sync_primed <= 2'b00;
    end else begin
      rxd_meta    <= rxd;
      rxd_sync    <= rxd_meta;
      sync_primed <= {sync_primed[0], 1'b1};
    end
  end

  assign tick = (tick_cnt == TICK_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
  end

  // sample_cnt holds the index of the latest sample within the current bit.
  assign sample_idx = sample_cnt + SAMPLE_W'(1);
  assign vote       = majority3(samp_early, samp_mid, rxd_sync);
  assign at_vote    = tick && (sample_idx == VOTE_LATE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE:    if (tick && armed && !rxd_sync) next_state = START;
      START:   if (at_vote) next_state = vote ? IDLE : DATA;
      DATA:    if (at_vote && bit_cnt == BIT_W'(DATA_BITS - 1)) next_state = STOP;
      STOP: begin
        if (at_vote) begin
          if (vote) begin
            push       = 1'b1;
            next_state = IDLE;
          end else begin
            frame_bad  = 1'b1;
            next_state = RECOVER;
          end
        end
      end
      RECOVER: if (tick && rxd_sync) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The synchronizer flops start at 1, so the line only counts as idle-high
  // once real samples have propagated through both stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      samp_early <= 1'b1;
      samp_mid   <= 1'b1;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      armed      <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (state == IDLE && sync_primed[1] && rxd_sync) armed <= 1'b1;
      frame_err <= frame_bad;
      overrun   <= push && fifo_full && !dout_ready;
      if (tick) begin
        if (state == IDLE) begin
          sample_cnt <= '0;
          bit_cnt    <= '0;
        end else begin
          sample_cnt <= sample_idx;
          if (sample_idx == VOTE_EARLY) samp_early <= rxd_sync;
          if (sample_idx == VOTE_MID)   samp_mid   <= rxd_sync;
          if (state == DATA && sample_idx == VOTE_LATE) begin
            shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + BIT_W'(1);
          end
        end
      end
    end
  end

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift_reg),
    .pop   (dout_ready),
    .head  (dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign dout_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus a randomized
// frame stream compared against a queue-based model of received bytes.
module tb_uart_rx_fifo;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = CLK_DIV * 16;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       dout_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] obs_q[$];
  int         fe_total = 0;
  int         ov_total = 0;

  logic [7:0] exp_q[$];
  int         exp_fe;
  int         exp_ov;
  int         base;
  int         fe_base;
  int         ov_base;
  int         waited;
  logic       busy_seen;
  logic       rand_done;
  logic [7:0] rbyte;
  logic       rstop;

  uart_rx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe accepted bytes and flag pulses mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && dout_ready) obs_q.push_back(dout);
      if (frame_err) fe_total++;
      if (overrun)   ov_total++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveLevel(input logic level, input int clks);
    rxd = level;
    repeat (clks) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    driveLevel(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) driveLevel(data[i], BIT_CLKS);
    driveLevel(stop_bit, BIT_CLKS);
  endtask

  task automatic waitBeats(input int target, input int limit);
    int n;
    n = 0;
    while (obs_q.size() < target && n < limit) begin
      @(posedge clk);
      #2;
      n++;
    end
  endtask

  task automatic waitBusyLow(input int limit);
    waited = 0;
    while (busy && waited < limit) begin
      @(posedge clk);
      #2;
      waited++;
    end
  endtask

  task automatic markBase();
    base    = obs_q.size();
    fe_base = fe_total;
    ov_base = ov_total;
    exp_q.delete();
    exp_fe  = 0;
    exp_ov  = 0;
  endtask

  task automatic checkFrames(input string tag);
    checkOutput({tag, "_count"}, 32'(obs_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < obs_q.size())
        checkOutput($sformatf("%s_byte%0d", tag, i), 32'(obs_q[base + i]), 32'(exp_q[i]));
    end
    checkOutput({tag, "_frame_err"}, 32'(fe_total - fe_base), 32'(exp_fe));
    checkOutput({tag, "_overrun"}, 32'(ov_total - ov_base), 32'(exp_ov));
  endtask

  initial begin
    rst        = 1'b1;
    rxd        = 1'b0;
    dout_ready = 1'b0;

    // Reset values, and no frame start while the line has never been high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_dout", 32'(dout), 32'h0);
    checkOutput("rst_valid", 32'(dout_valid), 32'h0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
    checkOutput("rst_overrun", 32'(overrun), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    busy_seen = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #2;
      if (busy) busy_seen = 1'b1;
    end
    checkOutput("no_start_while_low", 32'(busy_seen), 32'h0);
    checkOutput("no_bytes_while_low", 32'(obs_q.size()), 32'h0);
    driveLevel(1'b1, 50);

    // Single clean frame.
    dout_ready = 1'b1;
    markBase();
    applyStimulus(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    waitBeats(base + 1, 200);
    driveLevel(1'b1, 20);
    checkFrames("a5");

    // Short low glitch is rejected.
    markBase();
    driveLevel(1'b0, 12);
    rxd = 1'b1;
    waitBusyLow(40);
    checkOutput("glitch_busy_clear", 32'(busy), 32'h0);
    driveLevel(1'b1, 100);
    checkFrames("glitch");

    // Bad stop bit followed by a held break.
    markBase();
    applyStimulus(8'h3C, 1'b0);
    driveLevel(1'b0, 2 * BIT_CLKS);
    exp_fe = 1;
    checkOutput("break_busy_held", 32'(busy), 32'h1);
    checkOutput("break_fifo_empty", 32'(dout_valid), 32'h0);
    rxd = 1'b1;
    waitBusyLow(40);
    checkOutput("break_busy_clear", 32'(busy), 32'h0);
    driveLevel(1'b1, 50);
    checkFrames("break");

    // Fill the buffer with the consumer stalled; model keeps the oldest entries.
    dout_ready = 1'b0;
    markBase();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(8'(k), 1'b1);
      if (k <= FIFO_DEPTH) exp_q.push_back(8'(k));
      else                 exp_ov++;
      checkOutput($sformatf("ovr_after_frame%0d", k), 32'(ov_total - ov_base), 32'(exp_ov));
    end
    driveLevel(1'b1, 20);
    checkOutput("ovr_valid_held", 32'(dout_valid), 32'h1);
    checkOutput("ovr_head", 32'(dout), 32'(exp_q[0]));
    dout_ready = 1'b1;
    waitBeats(base + exp_q.size(), 100);
    driveLevel(1'b1, 10);
    checkFrames("ovr");
    checkOutput("ovr_drained", 32'(dout_valid), 32'h0);

    // Reset in the middle of data bit 3.
    rbyte = 8'hC3;
    driveLevel(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) driveLevel(rbyte[i], BIT_CLKS);
    driveLevel(rbyte[3], BIT_CLKS / 2);
    checkOutput("midrst_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_dout", 32'(dout), 32'h0);
    checkOutput("midrst_valid", 32'(dout_valid), 32'h0);
    checkOutput("midrst_frame_err", 32'(frame_err), 32'h0);
    checkOutput("midrst_overrun", 32'(overrun), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    driveLevel(1'b1, 100);
    markBase();
    applyStimulus(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    waitBeats(base + 1, 200);
    driveLevel(1'b1, 20);
    checkFrames("after_rst");

    // Back-to-back frames with no idle gap.
    markBase();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    waitBeats(base + 2, 200);
    driveLevel(1'b1, 20);
    checkFrames("b2b");

    // Random bytes, occasional bad stop bits, randomly stalling consumer.
    markBase();
    rand_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          rbyte = 8'($urandom_range(0, 255));
          rstop = ($urandom_range(0, 4) != 0);
          applyStimulus(rbyte, rstop);
          if (rstop) exp_q.push_back(rbyte);
          else       exp_fe++;
          driveLevel(1'b1, $urandom_range(16, 40));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          dout_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk);
    #2;
    dout_ready = 1'b1;
    waitBeats(base + exp_q.size(), 200);
    driveLevel(1'b1, 20);
    checkFrames("rand");
    checkOutput("final_idle", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
